// File: rtl/axis_operand_pairer_pkg.sv
// Shared definitions for axis_operand_pairer: FSM state encoding and a
// saturating counter increment helper.
package axis_operand_pairer_pkg;

    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_HAVE_A = 1'b1;

    // Increments value but sticks at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/axis_operand_pairer.sv
// Packs consecutive operand beats into {first, second} double-width beats.
// Define AXIS_PAIRER_ZERO_PAD_EN to emit {orphan, 0} for odd-length packets instead of dropping it.
module axis_operand_pairer #(
    parameter int c_WIDTH     = 8,
    parameter int c_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [c_WIDTH-1:0]     s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [2*c_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [c_CNT_WIDTH-1:0] orphan_cnt
);
    import axis_operand_pairer_pkg::*;

    logic [0:0]             state_q,  state_d;
    logic [c_WIDTH-1:0]     hold_q,   hold_d;
    logic [2*c_WIDTH-1:0]   m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q,  m_last_d;
    logic [c_CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic                   out_free;
    logic                   accept;

    // The output slot can take a new pair if empty or draining this cycle.
    assign out_free = !m_valid_q || m_axis_tready;

    always_comb begin
        s_axis_tready = out_free;
        if (state_q == S_EMPTY) begin
`ifdef AXIS_PAIRER_ZERO_PAD_EN
            s_axis_tready = s_axis_tlast ? out_free : 1'b1;
`else
            s_axis_tready = 1'b1;
`endif
        end
    end

    assign accept = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_axis_tready;
        m_last_d  = m_last_q;
        cnt_d     = cnt_q;
        if (accept) begin
            case (state_q)
                S_EMPTY: begin
                    if (!s_axis_tlast) begin
                        hold_d  = s_axis_tdata;
                        state_d = S_HAVE_A;
                    end else begin
                        cnt_d = c_CNT_WIDTH'(sat_inc(32'(cnt_q), c_CNT_WIDTH));
`ifdef AXIS_PAIRER_ZERO_PAD_EN
                        m_data_d  = {s_axis_tdata, {c_WIDTH{1'b0}}};
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
`endif
                    end
                end
                default: begin
                    m_data_d  = {hold_q, s_axis_tdata};
                    m_valid_d = 1'b1;
                    m_last_d  = s_axis_tlast;
                    state_d   = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            hold_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign orphan_cnt    = cnt_q;

endmodule
